// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and its command sequencer:
// op-codes, the queued command record and the sequencer state encoding.
package alu_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_NOTB = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_OR   = 2'b11;

  typedef struct packed {
    logic [1:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              acc_sel;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RESULT = 2'd2
  } seq_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO with synchronous active-low reset.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign rdata   = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, issues them one at a time to an external combinational
// ALU, and returns each captured result over a valid/ready interface.
import alu_pkg::*;

module alu_cmd_sequencer #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_acc,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_s,
  input  logic [DATA_W-1:0] alu_f,
  input  logic              alu_ovf,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_ovf,
  output logic [DATA_W-1:0] acc,
  output logic              ovf_sticky,
  input  logic              clr_sticky,
  output logic              busy
);

  seq_state_e        state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0]        alu_s_q, alu_s_d;
  logic [DATA_W-1:0] res_data_q, res_data_d, acc_q, acc_d;
  logic              res_ovf_q, res_ovf_d, sticky_q, sticky_d;
  alu_cmd_t          push_cmd, head_cmd;
  logic              fifo_pop, fifo_full, fifo_empty;

  assign push_cmd = '{op: cmd_op, a: cmd_a, b: cmd_b, acc_sel: cmd_acc};

  sync_fifo #(
    .WIDTH($bits(alu_cmd_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (cmd_valid),
    .wdata(push_cmd),
    .pop  (fifo_pop),
    .rdata(head_cmd),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Sequencer next-state; the ALU operands load on the same edge as the pop.
  always_comb begin
    state_d    = state_q;
    fifo_pop   = 1'b0;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_s_d    = alu_s_q;
    res_data_d = res_data_q;
    res_ovf_d  = res_ovf_q;
    acc_d      = acc_q;
    sticky_d   = clr_sticky ? 1'b0 : sticky_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          alu_s_d  = head_cmd.op;
          alu_b_d  = head_cmd.b;
          alu_a_d  = head_cmd.acc_sel ? acc_q : head_cmd.a;
          state_d  = ST_ISSUE;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        res_data_d = alu_f;
        res_ovf_d  = alu_ovf;
        acc_d      = alu_f;
        // A capture that overflows beats a simultaneous clear.
        sticky_d   = (clr_sticky ? 1'b0 : sticky_q) | alu_ovf;
        state_d    = ST_RESULT;
      end
      ST_RESULT: begin
        if (res_ready && !fifo_empty) begin
          fifo_pop = 1'b1;
          alu_s_d  = head_cmd.op;
          alu_b_d  = head_cmd.b;
          alu_a_d  = head_cmd.acc_sel ? acc_q : head_cmd.a;
          state_d  = ST_ISSUE;
        end else if (res_ready) begin
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_RESULT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, ALU drive and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_s_q    <= 2'b00;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
      acc_q      <= '0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_s_q    <= alu_s_d;
      res_data_q <= res_data_d;
      res_ovf_q  <= res_ovf_d;
      acc_q      <= acc_d;
      sticky_q   <= sticky_d;
    end
  end

  assign cmd_ready  = !fifo_full;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_s      = alu_s_q;
  assign res_valid  = (state_q == ST_RESULT);
  assign res_data   = res_data_q;
  assign res_ovf    = res_ovf_q;
  assign acc        = acc_q;
  assign ovf_sticky = sticky_q;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural 8-bit ALU.
// Expected results are queued on command acceptance and compared on output.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       acc_sel;
    logic [7:0] f;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [7:0] f;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, cmd_valid, cmd_ready, cmd_acc;
  logic [1:0] cmd_op, alu_s;
  logic [7:0] cmd_a, cmd_b, alu_a, alu_b, alu_f, res_data, acc;
  logic       alu_ovf, res_valid, res_ready, res_ovf, ovf_sticky, clr_sticky, busy;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_f(alu_f), .alu_ovf(alu_ovf),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_ovf(res_ovf),
    .acc(acc), .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky), .busy(busy)
  );

  // Behavioural ALU standing in for the real combinational one.
  always_comb begin
    alu_f   = 8'h00;
    alu_ovf = 1'b0;
    case (alu_s)
      2'b00: begin
        alu_f   = alu_a + alu_b;
        alu_ovf = (alu_a[7] == alu_b[7]) && (alu_f[7] != alu_a[7]);
      end
      2'b01:   alu_f = ~alu_b;
      2'b10:   alu_f = alu_a & alu_b;
      default: alu_f = alu_a | alu_b;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: each result handshake is checked against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got %0h expected none", res_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("res_data", 32'(res_data), 32'(e.f));
        check("res_ovf", 32'(res_ovf), 32'(e.ovf));
        check("acc", 32'(acc), 32'(e.f));
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic sel, input logic [7:0] ef, input logic eo);
    int   n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = sel;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    if (ok) begin
      exp_q.push_back('{f: ef, ovf: eo});
    end else begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got cmd_ready 0 expected 1");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int   t[6];
    int   nres, cyc, nvalid;
    logic took, acc6, got;

    vecs[0] = '{OP_ADD,  8'h4C, 8'h5A, 1'b0, 8'hA6, 1'b1};
    vecs[1] = '{OP_ADD,  8'hF6, 8'hFF, 1'b0, 8'hF5, 1'b0};
    vecs[2] = '{OP_NOTB, 8'h33, 8'h64, 1'b0, 8'h9B, 1'b0};
    vecs[3] = '{OP_AND,  8'h57, 8'h57, 1'b0, 8'h57, 1'b0};
    vecs[4] = '{OP_OR,   8'h0B, 8'h8A, 1'b0, 8'h8B, 1'b0};
    vecs[5] = '{OP_ADD,  8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
    vecs[6] = '{OP_OR,   8'hAA, 8'h0F, 1'b1, 8'h3F, 1'b0};
    vecs[7] = '{OP_ADD,  8'h55, 8'h01, 1'b1, 8'h40, 1'b0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a = 8'h00; cmd_b = 8'h00;
    cmd_acc = 1'b0; res_ready = 1'b1; clr_sticky = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_sticky", 32'(ovf_sticky), 32'd0);
    check("rst_alu", 32'({alu_a, alu_b, alu_s}), 32'd0);
    check("rst_res", 32'({res_data, res_ovf}), 32'd0);
    @(posedge clk); #1;

    // Latency: accepted at edge N, res_valid first seen after edge N+2.
    send(OP_ADD, 8'h07, 8'h64, 1'b0, 8'h6B, 1'b0);
    @(negedge clk); check("lat_n1", 32'(res_valid), 32'd0);
    @(negedge clk); check("lat_n2", 32'(res_valid), 32'd0);
    @(negedge clk); check("lat_n3", 32'(res_valid), 32'd1);
    @(posedge clk); #1;
    drain();

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].acc_sel, vecs[i].f, vecs[i].ovf);
    end
    drain();
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("tbl_sticky", 32'(ovf_sticky), 32'd1);
    @(posedge clk); #1;

    // Sticky overflow set and clear.
    clr_sticky = 1'b1; @(posedge clk); #1; clr_sticky = 1'b0;
    @(negedge clk); check("clr_sticky", 32'(ovf_sticky), 32'd0);
    @(posedge clk); #1;
    send(OP_ADD, 8'h4C, 8'h5A, 1'b0, 8'hA6, 1'b1);
    drain();
    @(negedge clk); check("ovf_sticky_set", 32'(ovf_sticky), 32'd1);
    @(posedge clk); #1;
    clr_sticky = 1'b1; @(posedge clk); #1; clr_sticky = 1'b0;
    send(OP_ADD, 8'hF6, 8'hFF, 1'b0, 8'hF5, 1'b0);
    drain();
    @(negedge clk); check("no_ovf_sticky", 32'(ovf_sticky), 32'd0);
    @(posedge clk); #1;

    // Clear held high while an overflow is captured: the set wins.
    res_ready = 1'b0; clr_sticky = 1'b1;
    send(OP_ADD, 8'h4C, 8'h5A, 1'b0, 8'hA6, 1'b1);
    got = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (res_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("setwin_valid", 32'(got), 32'd1);
    check("setwin_sticky", 32'(ovf_sticky), 32'd1);
    @(negedge clk); check("setwin_cleared", 32'(ovf_sticky), 32'd0);
    @(posedge clk); #1;
    clr_sticky = 1'b0; res_ready = 1'b1;
    drain();

    // Backpressure: five accepted, sixth held off until results drain.
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(OP_OR, 8'(i), 8'h80, 1'b0, 8'h80 | 8'(i), 1'b0);
    end
    cmd_valid = 1'b1; cmd_op = OP_OR; cmd_a = 8'h05; cmd_b = 8'h80; cmd_acc = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    nres = 0; cyc = 0; acc6 = 1'b0;
    while (nres < 6 && cyc < 60) begin
      @(negedge clk);
      if (res_valid) begin
        t[nres] = cyc;
        nres++;
      end
      took = cmd_valid && cmd_ready;
      @(posedge clk); #1;
      cyc++;
      if (took) begin
        exp_q.push_back('{f: 8'h85, ovf: 1'b0});
        cmd_valid = 1'b0;
        acc6 = 1'b1;
      end
    end
    check("bp_results", 32'(nres), 32'd6);
    check("bp_sixth_taken", 32'(acc6), 32'd1);
    for (int k = 1; k < 5; k++) begin
      check("bp_gap", 32'(t[k] - t[k-1]), 32'd2);
    end
    cmd_valid = 1'b0;
    drain();

    // Reset while in ISSUE with two commands queued.
    send(OP_ADD, 8'h4C, 8'h5A, 1'b0, 8'hA6, 1'b1);
    send(OP_OR, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);
    send(OP_OR, 8'h04, 8'h08, 1'b0, 8'h0C, 1'b0);
    send(OP_OR, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_sticky", 32'(ovf_sticky), 32'd1);
    check("pre_rst_acc", 32'(acc), 32'hA6);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_acc", 32'(acc), 32'd0);
    check("mid_rst_sticky", 32'(ovf_sticky), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;
    nvalid = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (res_valid) nvalid++;
    end
    check("post_rst_stale", 32'(nvalid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Initiator/controller for the team's 8-bit combinational ALU. It accepts ALU commands over a valid/ready interface and buffers them in a small FIFO. It drives the ALU's a/b/s inputs, captures f/ovf, and returns results over a second valid/ready interface. It also maintains an accumulator register, for chained operations, and a sticky overflow flag.

Parameters:
DATA_W, 8, operand/result width; must match the ALU.
FIFO_DEPTH, 4, command FIFO entries; power of two, at least 2.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command FIFO can accept (= !full)
cmd_op  input  2  ALU select: 00 add, 01 not b, 10 and, 11 or
cmd_a  input  DATA_W  operand A
cmd_b  input  DATA_W  operand B
cmd_acc  input  1  1 = use the accumulator instead of cmd_a as the A operand
alu_a  output  DATA_W  to ALU a (registered)
alu_b  output  DATA_W  to ALU b (registered)
alu_s  output  2  to ALU s (registered)
alu_f  input  DATA_W  ALU result
alu_ovf  input  1  ALU signed-add overflow
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_data  output  DATA_W  captured result
res_ovf  output  1  captured overflow
acc  output  DATA_W  accumulator, equal to the last captured result
ovf_sticky  output  1  OR of all captured res_ovf since the last clear
clr_sticky  input  1  synchronous clear of ovf_sticky
busy  output  1  FSM not IDLE or FIFO not empty

Behaviour:
- Reset (rst_n = 0 at a rising edge):
  - FIFO empty.
  - FSM in IDLE.
  - alu_a, alu_b, alu_s, res_data, res_ovf, acc, ovf_sticky all 0.
  - res_valid 0, busy 0; cmd_ready 1 in the cycle after reset.
  - A reset mid-operation discards in-flight and queued commands and does not emit a result.
- FIFO push: on cmd_valid & cmd_ready. The FIFO stores {op, a, b, acc_sel}. It has no bypass, so cmd_ready depends only on full.
- FSM states are IDLE, ISSUE and RESULT.
  - IDLE: if the FIFO is not empty, pop and go to ISSUE.
  - Issue load (on the pop edge): register alu_s <= op, alu_b <= b, and alu_a <= (acc_sel ? acc : a). The acc value used is the one current at the pop edge.
  - ISSUE, one cycle: the ALU ports hold stable. At the end of the cycle:
    - res_data <= alu_f; res_ovf <= alu_ovf; acc <= alu_f.
    - ovf_sticky <= ovf_sticky | alu_ovf.
    - Go to RESULT.
  - RESULT: res_valid = 1, with res_data and res_ovf held stable until res_ready.
    - On res_valid & res_ready: if the FIFO is not empty, pop and go straight to ISSUE; otherwise go to IDLE.
- Latency: a command accepted at edge N into an idle, empty block gives res_valid = 1 from the cycle after edge N+2.
- Throughput: one result per 2 cycles with res_ready held high.
- Ordering: results come out strictly in command order. No command is dropped or duplicated under backpressure.
- alu_a, alu_b and alu_s keep their last values outside ISSUE; they have no glitch or return-to-zero requirement.
- res_ovf is passed through from the ALU for all ops; the ALU drives 0 for ops other than add.
- clr_sticky and an overflow capture in the same cycle: the set wins, so ovf_sticky = 1.
- A push to the full FIFO is impossible because cmd_ready = 0. Push and pop in the same cycle are legal when not full.
- Capacity: one command in flight (ISSUE/RESULT) plus FIFO_DEPTH queued.
- Arithmetic is modulo 2^DATA_W; the sequencer performs no arithmetic itself.

Decomposition:
- Shared package alu_pkg:
  - Op-code constants OP_ADD = 2'b00, OP_NOTB = 2'b01, OP_AND = 2'b10, OP_OR = 2'b11.
  - DATA_W default.
  - Command struct/typedef {op, a, b, acc_sel}.
  - FSM state enum.
- One sub-module: sync_fifo (parameterised width and depth, synchronous active-low reset, full/empty flags). This FSM instantiates it; it is reusable elsewhere.
- The top-level test harness instantiates the ALU separately and wires alu_* to it.

Test Plan:
1. Add, no overflow: op 00, a = 0x07, b = 0x64 -> res_data 0x6B, res_ovf 0, acc 0x6B; res_valid rises 3 edges after acceptance.
2. Add with overflow: op 00, a = 0x4C, b = 0x5A -> res_data 0xA6, res_ovf 1, ovf_sticky 1. Then pulse clr_sticky -> ovf_sticky 0. Then op 00, a = 0xF6, b = 0xFF -> 0xF5, ovf 0.
3. Logic ops: not b with b = 0x64 -> 0x9B; and with a = b = 0x57 -> 0x57; or with a = 0x0B, b = 0x8A -> 0x8B; all with res_ovf 0.
4. Accumulator chain: add 0x10 + 0x20 -> 0x30; then cmd_acc = 1, op or, b = 0x0F -> 0x3F; then cmd_acc = 1, op add, b = 0x01 -> 0x40.
5. Backpressure: res_ready = 0 with 6 back-to-back commands -> 5 accepted (1 in flight + 4 queued) and cmd_ready low on the 6th. Release res_ready -> 5 results in order at 2 cycles each, then the 6th is accepted.
6. Reset mid-op: assert rst_n = 0 while in ISSUE with 2 queued -> next cycle res_valid 0, acc 0, ovf_sticky 0, busy 0, cmd_ready 1, and no stale result after reset is released.
